// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: sample stream, working-memory, core handshake and status signals
interface fft_frame_sequencer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_re;
  logic [DATA_WIDTH-1:0]   in_im;
  logic                    load_we;
  logic [AW-1:0]           load_addr;
  logic [2*DATA_WIDTH-1:0] load_data;
  logic                    fft_start;
  logic                    fft_finish;
  logic                    rd_bank;
  logic [AW-1:0]           rd_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_re;
  logic [DATA_WIDTH-1:0]   out_im;
  logic                    out_last;
  logic                    busy;
  logic                    error;
  logic [15:0]             frame_count;
  modport master (
    input  in_valid, in_re, in_im, fft_finish, rd_data, out_ready,
    output in_ready, load_we, load_addr, load_data, fft_start, rd_bank, rd_addr,
           out_valid, out_re, out_im, out_last, busy, error, frame_count
  );
  modport slave (
    output in_valid, in_re, in_im, fft_finish, rd_data, out_ready,
    input  in_ready, load_we, load_addr, load_data, fft_start, rd_bank, rd_addr,
           out_valid, out_re, out_im, out_last, busy, error, frame_count
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads N samples into bank 0, runs the FFT core under a watchdog,
// then drains the result bank through a 2-entry output/skid buffer.
module fft_frame_sequencer #(
  parameter int N                = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int BIT_REVERSE_LOAD = 1,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  fft_frame_sequencer_if.master bus
);
  localparam int AW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = 2 * DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [AW:0]     rd_cnt_q, rd_cnt_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            pend_q, pend_d, pend_last_q, pend_last_d;
  logic            ov_q, ov_d, ol_q, ol_d, sv_q, sv_d, sl_q, sl_d;
  logic [DW-1:0]   od_q, od_d, sd_q, sd_d;
  logic            err_q, err_d;
  logic [15:0]     fc_q, fc_d;
  logic            hs, pop, issue;
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
  endfunction
  assign bus.in_ready    = rst_n & (state_q == IDLE || state_q == LOAD);
  assign hs              = bus.in_valid & bus.in_ready;
  assign bus.load_we     = hs;
  assign bus.load_addr   = hs ? (BIT_REVERSE_LOAD != 0 ? bitrev(ld_cnt_q) : ld_cnt_q) : '0;
  assign bus.load_data   = hs ? {bus.in_re, bus.in_im} : '0;
  assign bus.fft_start   = state_q == START;
  assign bus.rd_bank     = 1'(AW % 2);
  assign bus.rd_addr     = rd_cnt_q[AW-1:0];
  assign bus.out_valid   = ov_q;
  assign bus.out_re      = od_q[DW-1:DATA_WIDTH];
  assign bus.out_im      = od_q[DATA_WIDTH-1:0];
  assign bus.out_last    = ol_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.error       = err_q;
  assign bus.frame_count = fc_q;
  assign pop             = ov_q & bus.out_ready;
  // Occupancy counts the head entry as free when it leaves this cycle, so a full-rate stream has no bubbles
  assign issue = state_q == DRAIN && rd_cnt_q != (AW+1)'(N) &&
                 2'(ov_q & ~bus.out_ready) + 2'(sv_q) + 2'(pend_q) < 2'd2;
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wd_d        = wd_q;
    err_d       = err_q;
    fc_d        = fc_q;
    pend_d      = issue;
    pend_last_d = rd_cnt_q[AW-1:0] == AW'(N-1);
    ov_d        = ov_q;
    od_d        = od_q;
    ol_d        = ol_q;
    sv_d        = sv_q;
    sd_d        = sd_q;
    sl_d        = sl_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d  = LOAD;
        ld_cnt_d = AW'(1);
        err_d    = 1'b0;
      end
      LOAD: if (hs) begin
        ld_cnt_d = ld_cnt_q + AW'(1);
        state_d  = ld_cnt_q == AW'(N-1) ? START : LOAD;
      end
      START: begin
        state_d = RUN;
        wd_d    = '0;
      end
      RUN: if (bus.fft_finish) begin
        state_d  = DRAIN;
        rd_cnt_d = '0;
      end else if (wd_q == WW'(TIMEOUT_CYCLES-1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + WW'(1);
      end
      DRAIN: begin
        rd_cnt_d = issue ? rd_cnt_q + (AW+1)'(1) : rd_cnt_q;
        if (pop && ol_q) begin
          state_d  = IDLE;
          fc_d     = fc_q + 16'd1;
          rd_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ov_q || pop) begin
      ov_d = sv_q | pend_q;
      od_d = sv_q ? sd_q : pend_q ? bus.rd_data : od_q;
      ol_d = sv_q ? sl_q : pend_q & pend_last_q;
      sv_d = sv_q & pend_q;
      sd_d = bus.rd_data;
      sl_d = pend_last_q;
    end else if (pend_q) begin
      sv_d = 1'b1;
      sd_d = bus.rd_data;
      sl_d = pend_last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      fc_q        <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      ov_q        <= 1'b0;
      od_q        <= '0;
      ol_q        <= 1'b0;
      sv_q        <= 1'b0;
      sd_q        <= '0;
      sl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      fc_q        <= fc_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      ol_q        <= ol_d;
      sv_q        <= sv_d;
      sd_q        <= sd_d;
      sl_q        <= sl_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: scoreboard bench with a stub FFT core and registered result memory
module tb_fft_frame_sequencer;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int TO = 32;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  bit   rnd = 1'b0;
  logic [32:0] sb [$];
  int   brev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  fft_frame_sequencer_if #(.N(N), .DATA_WIDTH(DW)) bus ();
  fft_frame_sequencer #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE_LOAD(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );
  always #5 clk = ~clk;
  // Result bank model: word at address a holds {a, a}, one cycle read latency
  always @(posedge clk) bus.rd_data <= {13'd0, bus.rd_addr, 13'd0, bus.rd_addr};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) chk("extra_out", 1, 0);
      else begin
        chk("out_sample", {bus.out_last, bus.out_re, bus.out_im}, sb[0]);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic load(input int cnt, input bit push, input bit spur);
    for (int k = 0; k < cnt; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_re      = 16'(k);
      bus.in_im      = 16'd0;
      bus.fft_finish = spur && k == 3;
      #1;
      chk("in_ready", bus.in_ready, 1);
      chk("load_we", bus.load_we, 1);
      chk("load_addr", bus.load_addr, 64'(brev[k]));
      chk("load_data", bus.load_data, {16'(k), 16'h0});
      tick;
      bus.fft_finish = 1'b0;
      if (k == 0) chk("err_clr", bus.error, 0);
    end
    bus.in_valid = 1'b0;
    if (push) for (int i = 0; i < N; i++) sb.push_back({i == N - 1, 16'(i), 16'(i)});
    if (cnt == N) begin
      #1;
      chk("fft_start", bus.fft_start, 1);
      chk("start_ready", bus.in_ready, 0);
    end
  endtask
  task automatic run_frame(input bit r, input bit spur, input logic [15:0] fc_exp);
    int n;
    bit done;
    rnd = r;
    n_out = 0;
    load(N, 1'b1, spur);
    repeat (19) tick;
    chk("run_no_start", bus.fft_start, 0);
    bus.fft_finish = 1'b1;
    tick;
    bus.fft_finish = 1'b0;
    chk("ov_edge1", bus.out_valid, 0);
    tick;
    chk("ov_edge2", bus.out_valid, 0);
    tick;
    chk("ov_rise", bus.out_valid, 1);
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      done = bus.out_valid && bus.out_ready && bus.out_last;
      tick;
      n++;
    end
    chk("drain_done", done, 1);
    if (!r) chk("drain_cycles", n, 8);
    chk("n_out", n_out, 8);
    chk("sb_empty", sb.size(), 0);
    chk("frame_count", bus.frame_count, fc_exp);
    chk("idle_busy", bus.busy, 0);
    chk("next_ready", bus.in_ready, 1);
  endtask
  initial begin
    int n;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_re      = '0;
    bus.in_im      = '0;
    bus.fft_finish = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) tick;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", {bus.out_last, bus.out_re, bus.out_im}, 0);
    chk("rst_status", {bus.error, bus.frame_count}, 0);
    chk("rst_mem", {bus.load_we, bus.load_addr, bus.load_data, bus.fft_start, bus.rd_addr}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rd_bank", bus.rd_bank, 1);
    run_frame(1'b0, 1'b0, 16'd1);
    run_frame(1'b1, 1'b0, 16'd2);
    run_frame(1'b1, 1'b1, 16'd3);
    rnd = 1'b0;
    load(N, 1'b0, 1'b0);
    n = 0;
    while (!bus.error && n < 100) begin
      tick;
      n++;
    end
    chk("timeout_lat", n, TO + 1);
    chk("timeout_err", bus.error, 1);
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_ov", bus.out_valid, 0);
    run_frame(1'b0, 1'b0, 16'd4);
    load(3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", bus.in_ready, 0);
    tick;
    chk("mid_busy", bus.busy, 0);
    chk("mid_status", {bus.error, bus.frame_count}, 0);
    chk("mid_out", {bus.out_valid, bus.out_last, bus.out_re, bus.out_im}, 0);
    chk("mid_mem", {bus.load_we, bus.load_addr, bus.load_data, bus.fft_start, bus.rd_addr}, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", bus.in_ready, 1);
    run_frame(1'b1, 1'b0, 16'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
